// File: rtl/pp_column_loader.sv
// Partial-product column loader for a WIDTH x WIDTH compressor tree: serially fills
// triangular column registers, waits LATENCY cycles, then captures and checks the result.
module pp_column_loader #(
  parameter  int WIDTH   = 26,
  parameter  int LATENCY = 0,
  parameter  int ERR_W   = 16,
  localparam int COLS    = 2*WIDTH-1,
  localparam int TOTAL   = WIDTH*WIDTH,
  localparam int RES_W   = 2*WIDTH,
  localparam int LCW     = $clog2(WIDTH+1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             shift_en,
  input  logic [COLS-1:0]  src_in,
  input  logic             ack,
  input  logic [RES_W-1:0] result_in,
  output logic [TOTAL-1:0] pp_flat,
  output logic [RES_W-1:0] res_q,
  output logic [RES_W-1:0] golden_q,
  output logic             done,
  output logic             mismatch,
  output logic             busy,
  output logic [LCW-1:0]   load_cnt,
  output logic [ERR_W-1:0] err_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WAIT, S_DONE} state_t;

  function automatic int col_h(input int i);
    return (i+1 < 2*WIDTH-1-i) ? i+1 : 2*WIDTH-1-i;
  endfunction

  function automatic int col_off(input int i);
    int s;
    s = 0;
    for (int unsigned j = 0; j < i; j++) s += col_h(j);
    return s;
  endfunction

  function automatic logic [RES_W-1:0] popcnt(input logic [WIDTH-1:0] v);
    logic [RES_W-1:0] c;
    c = '0;
    for (int unsigned b = 0; b < WIDTH; b++) c += RES_W'(v[b]);
    return c;
  endfunction

  state_t                     state;
  logic [3:0]                 wait_cnt;
  logic [TOTAL-1:0]           pp_q;
  logic [TOTAL-1:0]           pp_shift;
  logic [COLS:0][RES_W-1:0]   acc;
  logic [RES_W-1:0]           golden;

  // Each column shifts independently; acc chains the weighted popcounts column by column.
  assign acc[0] = '0;
  for (genvar i = 0; i < COLS; i++) begin : g_col
    localparam int H   = col_h(i);
    localparam int OFF = col_off(i);
    if (H == 1) begin : g_h1
      assign pp_shift[OFF] = src_in[i];
    end else begin : g_hn
      assign pp_shift[OFF +: H] = {pp_q[OFF +: H-1], src_in[i]};
    end
    assign acc[i+1] = acc[i] + (popcnt(WIDTH'(pp_q[OFF +: H])) << i);
  end

  assign golden  = acc[COLS];
  assign pp_flat = pp_q;
  assign busy    = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
      pp_q     <= '0;
      res_q    <= '0;
      golden_q <= '0;
      done     <= 1'b0;
      mismatch <= 1'b0;
      load_cnt <= '0;
      err_cnt  <= '0;
    end else if (start) begin
      state    <= S_LOAD;
      pp_q     <= '0;
      load_cnt <= '0;
      done     <= 1'b0;
      mismatch <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (shift_en) pp_q <= pp_shift;
        end
        S_LOAD: begin
          if (shift_en) begin
            pp_q     <= pp_shift;
            load_cnt <= load_cnt + LCW'(1);
            if (load_cnt == LCW'(WIDTH-1)) begin
              state    <= S_WAIT;
              wait_cnt <= '0;
            end
          end
        end
        S_WAIT: begin
          wait_cnt <= wait_cnt + 4'd1;
          if (wait_cnt == 4'(LATENCY)) begin
            res_q    <= result_in;
            golden_q <= golden;
            mismatch <= (result_in != golden);
            if ((result_in != golden) && (err_cnt != '1)) err_cnt <= err_cnt + ERR_W'(1);
            done     <= 1'b1;
            state    <= S_DONE;
          end
        end
        S_DONE: begin
          if (ack) begin
            done     <= 1'b0;
            mismatch <= 1'b0;
            state    <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pp_column_loader.sv
// Directed bench for pp_column_loader at WIDTH=4, LATENCY=2, plus an ERR_W=2 instance for saturation.
module tb_pp_column_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rst2_n = 1'b0;
  logic        start = 1'b0;
  logic        shift_en = 1'b0;
  logic [6:0]  src_in = '0;
  logic        ack = 1'b0;
  logic [7:0]  result_in = '0;

  logic [15:0] pp_flat, pp_flat2;
  logic [7:0]  res_q, golden_q, res_q2, golden_q2;
  logic        done, mismatch, busy, done2, mismatch2, busy2;
  logic [2:0]  load_cnt, load_cnt2;
  logic [15:0] err_cnt;
  logic [1:0]  err_cnt2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pp_column_loader #(.WIDTH(4), .LATENCY(2), .ERR_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .shift_en(shift_en), .src_in(src_in),
    .ack(ack), .result_in(result_in), .pp_flat(pp_flat), .res_q(res_q),
    .golden_q(golden_q), .done(done), .mismatch(mismatch), .busy(busy),
    .load_cnt(load_cnt), .err_cnt(err_cnt)
  );

  pp_column_loader #(.WIDTH(4), .LATENCY(2), .ERR_W(2)) dut_sat (
    .clk(clk), .rst_n(rst2_n), .start(start), .shift_en(shift_en), .src_in(src_in),
    .ack(ack), .result_in(result_in), .pp_flat(pp_flat2), .res_q(res_q2),
    .golden_q(golden_q2), .done(done2), .mismatch(mismatch2), .busy(busy2),
    .load_cnt(load_cnt2), .err_cnt(err_cnt2)
  );

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic shift(input logic [6:0] v);
    shift_en = 1'b1;
    src_in   = v;
    @(negedge clk);
    shift_en = 1'b0;
    src_in   = '0;
  endtask

  task automatic do_ack();
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
  endtask

  task automatic full_load(input logic [6:0] v);
    pulse_start();
    for (int k = 0; k < 4; k++) shift(v);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rst2_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1; rst2_n = 1'b1;
    @(negedge clk);
    pulse_start();
    shift(7'h7F);
    shift(7'h7F);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (pp_flat !== 16'h0000) begin failures++; $display("FAIL reset_pp got %h exp 0000", pp_flat); end
    checks++; if (load_cnt !== 3'd0) begin failures++; $display("FAIL reset_load_cnt got %0d exp 0", load_cnt); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got %b exp 0", done); end
    checks++; if (err_cnt !== 16'd0) begin failures++; $display("FAIL reset_err got %0d exp 0", err_cnt); end
    checks++; if (golden_q !== 8'h00 || res_q !== 8'h00) begin failures++; $display("FAIL reset_res got %h/%h exp 00/00", res_q, golden_q); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_full_load();
    result_in = 8'hE1;
    full_load(7'h7F);
    checks++; if (pp_flat !== 16'hFFFF) begin failures++; $display("FAIL load_pp got %h exp FFFF", pp_flat); end
    checks++; if (load_cnt !== 3'd4) begin failures++; $display("FAIL load_cnt got %0d exp 4", load_cnt); end
    checks++; if (busy !== 1'b1 || done !== 1'b0) begin failures++; $display("FAIL load_wait_state got busy=%b done=%b exp 1/0", busy, done); end
    repeat (2) @(negedge clk);
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL early_done got %b exp 0", done); end
    @(negedge clk);
    checks++; if (done !== 1'b1) begin failures++; $display("FAIL capture_done got %b exp 1", done); end
    checks++; if (golden_q !== 8'hE1) begin failures++; $display("FAIL golden_full got %h exp E1", golden_q); end
    checks++; if (res_q !== 8'hE1) begin failures++; $display("FAIL res_full got %h exp E1", res_q); end
    checks++; if (mismatch !== 1'b0) begin failures++; $display("FAIL mismatch_full got %b exp 0", mismatch); end
    checks++; if (err_cnt !== 16'd0) begin failures++; $display("FAIL err_full got %0d exp 0", err_cnt); end
    do_ack();
  endtask

  task automatic test_mismatch();
    result_in = 8'hE0;
    full_load(7'h7F);
    repeat (3) @(negedge clk);
    checks++; if (done !== 1'b1 || mismatch !== 1'b1) begin failures++; $display("FAIL mm_flag got done=%b mm=%b exp 1/1", done, mismatch); end
    checks++; if (err_cnt !== 16'd1) begin failures++; $display("FAIL mm_err got %0d exp 1", err_cnt); end
    checks++; if (res_q !== 8'hE0) begin failures++; $display("FAIL mm_res got %h exp E0", res_q); end
    do_ack();
    checks++; if (done !== 1'b0 || busy !== 1'b0 || mismatch !== 1'b0) begin failures++; $display("FAIL ack_idle got done=%b busy=%b mm=%b exp 0/0/0", done, busy, mismatch); end
    checks++; if (pp_flat !== 16'hFFFF) begin failures++; $display("FAIL ack_keep_pp got %h exp FFFF", pp_flat); end
  endtask

  task automatic test_truncation();
    result_in = 8'h08;
    pulse_start();
    shift(7'h09);
    shift(7'h00); shift(7'h00); shift(7'h00);
    checks++; if (pp_flat[0] !== 1'b0) begin failures++; $display("FAIL trunc_col0 got %b exp 0", pp_flat[0]); end
    checks++; if (pp_flat[9:6] !== 4'b1000) begin failures++; $display("FAIL trunc_col3 got %b exp 1000", pp_flat[9:6]); end
    checks++; if (pp_flat !== 16'h0200) begin failures++; $display("FAIL trunc_pp got %h exp 0200", pp_flat); end
    repeat (3) @(negedge clk);
    checks++; if (golden_q !== 8'h08) begin failures++; $display("FAIL trunc_golden got %h exp 08", golden_q); end
    checks++; if (mismatch !== 1'b0 || err_cnt !== 16'd1) begin failures++; $display("FAIL trunc_mm got mm=%b err=%0d exp 0/1", mismatch, err_cnt); end
    do_ack();
  endtask

  task automatic test_stall_ignore();
    result_in = 8'h24;
    pulse_start();
    shift(7'h7F);
    shift(7'h7F);
    repeat (5) @(negedge clk);
    checks++; if (load_cnt !== 3'd2) begin failures++; $display("FAIL stall_cnt got %0d exp 2", load_cnt); end
    checks++; if (pp_flat !== 16'hECDF) begin failures++; $display("FAIL stall_pp got %h exp ECDF", pp_flat); end
    shift(7'h00);
    shift(7'h00);
    checks++; if (pp_flat !== 16'h1320) begin failures++; $display("FAIL shift_pp got %h exp 1320", pp_flat); end
    shift(7'h7F);
    checks++; if (pp_flat !== 16'h1320) begin failures++; $display("FAIL wait_ignore got %h exp 1320", pp_flat); end
    repeat (2) @(negedge clk);
    checks++; if (done !== 1'b1 || golden_q !== 8'h24) begin failures++; $display("FAIL stall_capture got done=%b golden=%h exp 1/24", done, golden_q); end
    shift(7'h7F);
    checks++; if (pp_flat !== 16'h1320 || done !== 1'b1) begin failures++; $display("FAIL done_ignore got pp=%h done=%b exp 1320/1", pp_flat, done); end
    start = 1'b1; shift_en = 1'b1; src_in = 7'h7F; ack = 1'b1;
    @(negedge clk);
    start = 1'b0; shift_en = 1'b0; src_in = '0; ack = 1'b0;
    checks++; if (pp_flat !== 16'h0000 || load_cnt !== 3'd0) begin failures++; $display("FAIL restart_clear got pp=%h cnt=%0d exp 0000/0", pp_flat, load_cnt); end
    checks++; if (busy !== 1'b1 || done !== 1'b0) begin failures++; $display("FAIL restart_state got busy=%b done=%b exp 1/0", busy, done); end
    checks++; if (golden_q !== 8'h24) begin failures++; $display("FAIL restart_keep got %h exp 24", golden_q); end
    shift(7'h7F);
    checks++; if (load_cnt !== 3'd1) begin failures++; $display("FAIL restart_load got %0d exp 1", load_cnt); end
  endtask

  task automatic test_saturation();
    logic [1:0] exp_err [4];
    exp_err = '{2'd1, 2'd2, 2'd3, 2'd3};
    rst2_n = 1'b0;
    @(negedge clk);
    rst2_n = 1'b1;
    result_in = 8'hE0;
    for (int r = 0; r < 4; r++) begin
      full_load(7'h7F);
      repeat (3) @(negedge clk);
      checks++;
      if (err_cnt2 !== exp_err[r] || mismatch2 !== 1'b1) begin
        failures++;
        $display("FAIL sat_run%0d got err=%0d mm=%b exp %0d/1", r, err_cnt2, mismatch2, exp_err[r]);
      end
      do_ack();
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_full_load();
    test_mismatch();
    test_truncation();
    test_stall_ignore();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
